// File: rtl/if_stage_if.sv
// Instruction memory request/response channel between the fetch stage and imem.
interface if_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests
// and drives the IF/ID register with stall and redirect (flush) support.
module if_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  if_stage_if.master  imem,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc,
  output logic        id_valid
);
  // state | meaning
  // IDLE  | dead cycle after reset release
  // FETCH | request at pc outstanding until gnt
  // WAIT  | request accepted, waiting for rvalid
  // HOLD  | response buffered while decode stalls
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] req_pc;
  logic [15:0] hold_buf;
  logic        discard;
  logic        load_id;
  logic [15:0] load_instr;

  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;

  always_comb begin
    load_id    = 1'b0;
    load_instr = imem.imem_rdata;
    if (!redirect_valid && !stall) begin
      if (state == WAIT && imem.imem_rvalid && !discard) begin
        load_id = 1'b1;
      end
      if (state == HOLD) begin
        load_id    = 1'b1;
        load_instr = hold_buf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_pc   <= '0;
      hold_buf <= '0;
      discard  <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (redirect_valid) begin
      // A grant in this cycle already launched the old-pc request; its reply is dropped.
      pc       <= redirect_pc;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      case (state)
        IDLE:  state <= FETCH;
        FETCH: begin
          if (imem.imem_gnt) begin
            req_pc  <= pc;
            discard <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            discard <= 1'b0;
            state   <= FETCH;
          end else begin
            discard <= 1'b1;
          end
        end
        HOLD:    state <= FETCH;
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: begin
          if (imem.imem_gnt) begin
            req_pc <= pc;
            pc     <= pc + 16'd1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= FETCH;
            end else if (!stall) begin
              state <= FETCH;
            end else begin
              hold_buf <= imem.imem_rdata;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) state <= FETCH;
        end
        default: state <= IDLE;
      endcase

      if (load_id) begin
        id_instr <= load_instr;
        id_pc    <= req_pc;
        id_valid <= 1'b1;
      end else if (!stall) begin
        id_instr <= NOP_INSTR;
        id_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic, checked cycle by
// cycle against a program-order delivery model with an imem responder.
module tb_if_stage;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP      = 16'h0000;
  localparam int          EV_GNT    = 0;
  localparam int          EV_RVALID = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic        id_valid;

  if_stage_if imem ();

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_valid       (id_valid)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit rand_mode = 1'b0;
  int dir_lat   = 1;

  // expected IF/ID contents and the next address in program order
  logic        exp_valid;
  logic [15:0] exp_instr, exp_pc, next_pc;
  // the one request in flight, and a response waiting for decode to accept it
  bit          out_valid, out_killed;
  int          out_left;
  logic [15:0] out_pc, out_mem_addr;
  bit          pend_valid;
  logic [15:0] pend_pc, pend_instr;
  logic        s_req;
  logic [15:0] s_addr;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic reset_model();
    exp_valid  = 1'b0;
    exp_instr  = NOP;
    exp_pc     = 16'h0;
    next_pc    = RESET_PC;
    out_valid  = 1'b0;
    out_killed = 1'b0;
    out_left   = 0;
    pend_valid = 1'b0;
  endtask

  task automatic model_update();
    if (!rst) begin
      reset_model();
      return;
    end
    if (imem.imem_rvalid && out_valid) begin
      if (!out_killed) begin
        pend_valid = 1'b1;
        pend_pc    = out_pc;
        pend_instr = out_pc ^ 16'hA500;
      end
      out_valid = 1'b0;
    end
    if (s_req && imem.imem_gnt) begin
      out_valid    = 1'b1;
      out_killed   = 1'b0;
      out_pc       = next_pc;
      out_mem_addr = s_addr;
      out_left     = rand_mode ? int'($urandom_range(1, 3)) : dir_lat;
      next_pc      = next_pc + 16'd1;
    end
    if (redirect_valid) begin
      out_killed = 1'b1;
      pend_valid = 1'b0;
      next_pc    = redirect_pc;
      exp_valid  = 1'b0;
      exp_instr  = NOP;
    end else if (pend_valid && !stall) begin
      exp_valid  = 1'b1;
      exp_pc     = pend_pc;
      exp_instr  = pend_instr;
      pend_valid = 1'b0;
    end else if (!stall) begin
      exp_valid = 1'b0;
      exp_instr = NOP;
    end
  endtask

  task automatic to_negedge();
    @(negedge clk);
    chk("id_valid", 16'(id_valid), 16'(exp_valid));
    chk("id_instr", id_instr, exp_instr);
    chk("id_pc", id_pc, exp_pc);
    s_req  = imem.imem_req;
    s_addr = imem.imem_addr;
    if (out_valid || pend_valid) chk("req_while_busy", 16'(s_req), 16'd0);
    else if (s_req) chk("fetch_addr", s_addr, next_pc);
    imem.imem_gnt    = s_req && (!rand_mode || ($urandom_range(0, 1) == 1));
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 16'($urandom);
    if (out_valid) begin
      if (out_left <= 1) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = out_mem_addr ^ 16'hA500;
      end else begin
        out_left--;
      end
    end
  endtask

  task automatic step(input logic st, input logic rd, input logic [15:0] rpc);
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    @(posedge clk);
    model_update();
    to_negedge();
  endtask

  task automatic advance_to(input int ev, input logic [15:0] a);
    bit hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ev == EV_GNT) hit = s_req && imem.imem_gnt && (next_pc == a);
      else              hit = imem.imem_rvalid && out_valid && (out_pc == a);
      if (hit) break;
      step(1'b0, 1'b0, 16'h0);
    end
    chk("advance_reached", 16'(hit), 16'd1);
  endtask

  task automatic next_valid(output logic [15:0] pc, output logic [15:0] instr);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      step(1'b0, 1'b0, 16'h0);
      got = id_valid;
    end
    chk("next_valid_seen", 16'(got), 16'd1);
    pc    = id_pc;
    instr = id_instr;
  endtask

  initial begin
    logic [15:0] pc, ins;
    imem.imem_gnt    = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 16'h0;
    reset_model();
    #1 rst = 1'b0;

    // reset state and the dead cycle after release
    to_negedge();
    chk("rst_id_valid", 16'(id_valid), 16'd0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_pc", id_pc, 16'h0000);
    chk("rst_req", 16'(imem.imem_req), 16'd0);
    step(1'b0, 1'b0, 16'h0);
    rst = 1'b1;
    chk("dead_cycle_req", 16'(imem.imem_req), 16'd0);
    step(1'b0, 1'b0, 16'h0);
    chk("first_req", 16'(imem.imem_req), 16'd1);
    chk("first_addr", imem.imem_addr, RESET_PC);

    // streaming at one instruction per two cycles
    next_valid(pc, ins);
    chk("p1_pc0", pc, 16'h0000);
    chk("p1_in0", ins, 16'hA500);
    step(1'b0, 1'b0, 16'h0);
    chk("p1_gap", 16'(id_valid), 16'd0);
    step(1'b0, 1'b0, 16'h0);
    chk("p1_v1", 16'(id_valid), 16'd1);
    chk("p1_pc1", id_pc, 16'h0001);
    chk("p1_in1", id_instr, 16'hA501);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    chk("p1_pc2", id_pc, 16'h0002);
    chk("p1_in2", id_instr, 16'hA502);

    // stall across the response for 0003
    advance_to(EV_RVALID, 16'h0003);
    chk("p2_pre_pc", id_pc, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h0);
      chk("p2_hold_pc", id_pc, 16'h0002);
      chk("p2_hold_valid", 16'(id_valid), 16'd0);
    end
    step(1'b0, 1'b0, 16'h0);
    chk("p2_rel_valid", 16'(id_valid), 16'd1);
    chk("p2_rel_pc", id_pc, 16'h0003);
    chk("p2_rel_in", id_instr, 16'hA503);
    next_valid(pc, ins);
    chk("p2_next_pc", pc, 16'h0004);

    // redirect while waiting for 0005 with a slow response
    advance_to(EV_GNT, 16'h0005);
    dir_lat = 3;
    step(1'b0, 1'b0, 16'h0);
    dir_lat = 1;
    step(1'b0, 1'b1, 16'h0040);
    chk("p3_bubble_valid", 16'(id_valid), 16'd0);
    chk("p3_bubble_instr", id_instr, NOP);
    advance_to(EV_GNT, 16'h0040);
    chk("p3_addr", imem.imem_addr, 16'h0040);
    next_valid(pc, ins);
    chk("p3_pc", pc, 16'h0040);
    chk("p3_in", ins, 16'hA540);

    // redirect coinciding with rvalid
    advance_to(EV_RVALID, 16'h0041);
    step(1'b0, 1'b1, 16'h0080);
    chk("p4a_bubble", 16'(id_valid), 16'd0);
    next_valid(pc, ins);
    chk("p4a_pc", pc, 16'h0080);
    chk("p4a_in", ins, 16'hA580);

    // redirect coinciding with gnt
    advance_to(EV_GNT, 16'h0081);
    step(1'b0, 1'b1, 16'h0080);
    advance_to(EV_GNT, 16'h0080);
    chk("p4b_addr", imem.imem_addr, 16'h0080);
    next_valid(pc, ins);
    chk("p4b_pc", pc, 16'h0080);
    chk("p4b_in", ins, 16'hA580);

    // PC wrap
    step(1'b0, 1'b1, 16'hFFFF);
    next_valid(pc, ins);
    chk("p5_pc0", pc, 16'hFFFF);
    chk("p5_in0", ins, 16'h5AFF);
    next_valid(pc, ins);
    chk("p5_pc1", pc, 16'h0000);
    chk("p5_in1", ins, 16'hA500);
    next_valid(pc, ins);
    chk("p5_pc2", pc, 16'h0001);
    chk("p5_in2", ins, 16'hA501);

    // reset mid-WAIT with the response landing inside reset
    advance_to(EV_GNT, 16'h0002);
    step(1'b0, 1'b0, 16'h0);
    chk("p6_rvalid_pending", 16'(imem.imem_rvalid), 16'd1);
    rst = 1'b0;
    #1;
    chk("p6_rst_valid", 16'(id_valid), 16'd0);
    chk("p6_rst_instr", id_instr, NOP);
    chk("p6_rst_pc", id_pc, 16'h0000);
    chk("p6_rst_req", 16'(imem.imem_req), 16'd0);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    rst = 1'b1;
    advance_to(EV_GNT, RESET_PC);
    chk("p6_restart_addr", imem.imem_addr, RESET_PC);
    next_valid(pc, ins);
    chk("p6_pc", pc, 16'h0000);
    chk("p6_in", ins, 16'hA500);

    // random gnt, latency, stall and redirect
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic        st, rd;
      logic [15:0] rpc;
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 2)) : 16'($urandom);
      step(st, rd, rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
